// File: rtl/lsq_dcache_ctrl_pkg.sv
// Shared types for the LSQ-facing blocking data cache: access sizes, bus
// commands, controller states and the LSQ request/response payloads.
package lsq_dcache_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 64;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned MTAG_W = 4;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_REQ  = 3'd1,
        LD_WAIT = 3'd2,
        ST_REQ  = 3'd3,
        RESP    = 3'd4
    } dcache_state_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] address;
        logic [WORD_W-1:0] value;
        mem_size_e         mem_size;
        logic              is_store;
    } dcache_in_packet_t;

    typedef struct packed {
        logic              completed;
        logic [WORD_W-1:0] value;
    } dcache_out_packet_t;

endpackage

// File: rtl/lsq_dcache_ctrl_lane_sel.sv
// Byte/half/word lane extract and merge on a 64-bit line, shared by the
// load-return and store-hit paths. Low offset bits below the access size are ignored.
module lsq_dcache_ctrl_lane_sel
    import lsq_dcache_ctrl_pkg::*;
(
    input  logic [63:0] line,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_c,
    output logic [63:0] merged_c
);

    always_comb begin
        rdata_c  = '0;
        merged_c = line;
        case (mem_size_e'(size))
            BYTE: begin
                rdata_c = 32'(line[{offset, 3'b000} +: 8]);
                merged_c[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            HALF: begin
                rdata_c = 32'(line[{offset[2:1], 4'b0000} +: 16]);
                merged_c[{offset[2:1], 4'b0000} +: 16] = wdata[15:0];
            end
            WORD, DOUBLE: begin
                rdata_c = line[{offset[2], 5'b00000} +: 32];
                merged_c[{offset[2], 5'b00000} +: 32] = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsq_dcache_ctrl.sv
// Blocking direct-mapped write-through, no-write-allocate data cache that
// answers the head-of-LSQ request and talks to the tagged memory bus.
module lsq_dcache_ctrl
    import lsq_dcache_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LINES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsq_is_requesting,
    input  logic [31:0] address,
    input  logic [31:0] value,
    input  logic [1:0]  mem_size,
    input  logic        is_store,
    output logic        completed,
    output logic [31:0] ld_value,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic [1:0]  proc2mem_size,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 32 - 3 - IDX_W;

    logic [63:0]          data_mem [NUM_LINES];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    dcache_state_e state;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic [3:0]    mem_tag;

    logic [IDX_W-1:0] in_idx_c, req_idx_c, line_idx_c;
    logic [TAG_W-1:0] in_tag_c, req_tag_c, line_tag_c;
    logic             hit_c, fill_c, accept_c, line_we_c;
    logic [63:0]      sel_line_c, line_wdata_c, lane_merged_c;
    logic [2:0]       sel_off_c;
    logic [1:0]       sel_size_c;
    logic [31:0]      lane_rdata_c;

    assign in_idx_c  = address[3 +: IDX_W];
    assign in_tag_c  = address[31 -: TAG_W];
    assign req_idx_c = req_addr[3 +: IDX_W];
    assign req_tag_c = req_addr[31 -: TAG_W];

    assign accept_c = (state == IDLE) && lsq_is_requesting;
    assign hit_c    = valid[in_idx_c] && (tag_mem[in_idx_c] == in_tag_c);
    assign fill_c   = (state == LD_WAIT) && (mem_tag != 4'd0) && (mem2proc_tag == mem_tag);

    // One lane unit: fill data on a returning miss, the cached line otherwise
    assign sel_line_c = (state == LD_WAIT) ? mem2proc_data : data_mem[in_idx_c];
    assign sel_off_c  = (state == LD_WAIT) ? req_addr[2:0] : address[2:0];
    assign sel_size_c = (state == LD_WAIT) ? req_size : mem_size;

    lsq_dcache_ctrl_lane_sel u_lane_sel (
        .line     (sel_line_c),
        .offset   (sel_off_c),
        .size     (sel_size_c),
        .wdata    (value),
        .rdata_c  (lane_rdata_c),
        .merged_c (lane_merged_c)
    );

    assign line_we_c    = (accept_c && is_store && hit_c) || fill_c;
    assign line_idx_c   = fill_c ? req_idx_c : in_idx_c;
    assign line_tag_c   = fill_c ? req_tag_c : in_tag_c;
    assign line_wdata_c = fill_c ? mem2proc_data : lane_merged_c;

    // Line storage carries no reset; the valid bits alone gate hits
    always_ff @(posedge clock) begin
        if (line_we_c) begin
            data_mem[line_idx_c] <= line_wdata_c;
            tag_mem[line_idx_c]  <= line_tag_c;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            completed        <= 1'b0;
            ld_value         <= '0;
            proc2mem_command <= BUS_NONE;
            proc2mem_addr    <= '0;
            proc2mem_data    <= '0;
            proc2mem_size    <= BYTE;
            mem_tag          <= '0;
            req_addr         <= '0;
            req_size         <= BYTE;
            valid            <= '0;
        end else begin
            completed <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsq_is_requesting) begin
                        req_addr <= address;
                        req_size <= mem_size;
                        if (is_store) begin
                            proc2mem_command <= BUS_STORE;
                            proc2mem_addr    <= address;
                            proc2mem_size    <= mem_size;
                            proc2mem_data    <= {32'h0, value};
                            state            <= ST_REQ;
                        end else if (hit_c) begin
                            ld_value  <= lane_rdata_c;
                            completed <= 1'b1;
                            state     <= RESP;
                        end else begin
                            proc2mem_command <= BUS_LOAD;
                            proc2mem_addr    <= {address[31:3], 3'b000};
                            proc2mem_size    <= DOUBLE;
                            state            <= LD_REQ;
                        end
                    end
                end
                LD_REQ: begin
                    if (mem2proc_response != 4'd0) begin
                        mem_tag          <= mem2proc_response;
                        proc2mem_command <= BUS_NONE;
                        state            <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (fill_c) begin
                        valid[req_idx_c] <= 1'b1;
                        ld_value         <= lane_rdata_c;
                        mem_tag          <= '0;
                        completed        <= 1'b1;
                        state            <= RESP;
                    end
                end
                ST_REQ: begin
                    if (mem2proc_response != 4'd0) begin
                        proc2mem_command <= BUS_NONE;
                        ld_value         <= '0;
                        completed        <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsq_dcache_ctrl.sv
// Directed bench for lsq_dcache_ctrl: scripted LSQ requests and memory
// replies with hand-computed bus commands, completions and load values.
module tb_lsq_dcache_ctrl;
    import lsq_dcache_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        lsq_is_requesting;
    logic [31:0] address;
    logic [31:0] value;
    logic [1:0]  mem_size;
    logic        is_store;
    logic        completed;
    logic [31:0] ld_value;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [1:0]  proc2mem_size;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_starts = 0;
    logic [1:0] prev_cmd = 2'd0;

    lsq_dcache_ctrl #(.NUM_LINES(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .lsq_is_requesting (lsq_is_requesting),
        .address           (address),
        .value             (value),
        .mem_size          (mem_size),
        .is_store          (is_store),
        .completed         (completed),
        .ld_value          (ld_value),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count completion pulses and fresh bus commands over whole sequences
    always @(posedge clock) begin
        if (completed === 1'b1) n_done++;
        if (proc2mem_command != 2'd0 && prev_cmd == 2'd0) n_starts++;
        prev_cmd = proc2mem_command;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request at the current negedge and carry it to completion.
    task automatic access(input string tg, input logic [31:0] a, input logic [31:0] v,
                          input logic [1:0] sz, input logic st, input logic miss,
                          input int retries, input logic [3:0] rtag,
                          input logic [63:0] fill, input logic [31:0] exp_val);
        logic [1:0]  exp_cmd;
        lsq_is_requesting = 1'b1;
        address  = a;
        value    = v;
        mem_size = sz;
        is_store = st;
        @(negedge clock);
        if (st || miss) begin
            exp_cmd  = st ? BUS_STORE : BUS_LOAD;
            // Captured request must survive the LSQ changing its fields
            address  = ~a;
            value    = ~v;
            mem_size = ~sz;
            is_store = ~st;
            for (int r = 0; r <= retries; r++) begin
                check_eq({tg, ".cmd"}, 64'(proc2mem_command), 64'(exp_cmd));
                if (r == 0) begin
                    check_eq({tg, ".addr"}, 64'(proc2mem_addr), st ? 64'(a) : 64'({a[31:3], 3'b000}));
                    check_eq({tg, ".size"}, 64'(proc2mem_size), st ? 64'(sz) : 64'(DOUBLE));
                    check_eq({tg, ".early_done"}, 64'(completed), 64'd0);
                    if (st) check_eq({tg, ".wdata"}, proc2mem_data, {32'h0, v});
                end
                mem2proc_response = (r == retries) ? rtag : 4'd0;
                @(negedge clock);
            end
            mem2proc_response = 4'd0;
            check_eq({tg, ".cmd_off"}, 64'(proc2mem_command), 64'(BUS_NONE));
            if (!st) begin
                mem2proc_tag  = rtag;
                mem2proc_data = fill;
                @(negedge clock);
                mem2proc_tag  = 4'd0;
            end
        end
        check_eq({tg, ".done"}, 64'(completed), 64'd1);
        check_eq({tg, ".value"}, 64'(ld_value), 64'(exp_val));
        lsq_is_requesting = 1'b0;
        @(negedge clock);
        check_eq({tg, ".pulse"}, 64'(completed), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s0;
        reset             = 1'b0;
        lsq_is_requesting = 1'b0;
        address           = '0;
        value             = '0;
        mem_size          = 2'd0;
        is_store          = 1'b0;
        mem2proc_response = '0;
        mem2proc_data     = '0;
        mem2proc_tag      = '0;
        repeat (3) @(negedge clock);
        check_eq("rst.completed", 64'(completed), 64'd0);
        check_eq("rst.ld_value", 64'(ld_value), 64'd0);
        check_eq("rst.cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check_eq("rst.addr", 64'(proc2mem_addr), 64'd0);
        check_eq("rst.data", proc2mem_data, 64'd0);
        check_eq("rst.size", 64'(proc2mem_size), 64'(BYTE));
        reset = 1'b1;
        @(negedge clock);

        // Cold miss with two retry cycles, then a hit on the other word
        access("cold_lw", 32'h1000, 32'h0, WORD, 1'b0, 1'b1, 2, 4'd3,
               64'h11223344_AABBCCDD, 32'hAABBCCDD);
        access("hit_lw", 32'h1004, 32'h0, WORD, 1'b0, 1'b0, 0, 4'd0, 64'h0, 32'h11223344);

        // Store hit merges byte 1; write-through still goes on the bus
        access("sb_hit", 32'h1001, 32'h000000EE, BYTE, 1'b1, 1'b0, 1, 4'd2, 64'h0, 32'h0);
        access("lw_merged", 32'h1000, 32'h0, WORD, 1'b0, 1'b0, 0, 4'd0, 64'h0, 32'hAABBEEDD);

        // Store miss must not allocate or disturb the resident line
        access("sw_miss", 32'h2000, 32'hDEADBEEF, WORD, 1'b1, 1'b0, 0, 4'd1, 64'h0, 32'h0);
        access("lw_still", 32'h1000, 32'h0, WORD, 1'b0, 1'b0, 0, 4'd0, 64'h0, 32'hAABBEEDD);
        access("lw_2000", 32'h2000, 32'h0, WORD, 1'b0, 1'b1, 0, 4'd4,
               64'h00000000_DEADBEEF, 32'hDEADBEEF);

        // Three same-index lines in a row: every one misses
        s0 = n_starts;
        access("ev_a", 32'h1000, 32'h0, WORD, 1'b0, 1'b1, 0, 4'd6,
               64'h11223344_AABBEEDD, 32'hAABBEEDD);
        access("ev_b", 32'h1106, 32'h0, HALF, 1'b0, 1'b1, 0, 4'd7,
               64'h55667788_99AA0011, 32'h00005566);
        access("ev_c", 32'h1003, 32'h0, BYTE, 1'b0, 1'b1, 0, 4'd8,
               64'h11223344_AABBEEDD, 32'h000000AA);
        check_eq("evict.bus_loads", 64'(n_starts - s0), 64'd3);

        // Back-to-back: next request presented the cycle after each completion
        d0 = n_done;
        s0 = n_starts;
        access("b2b_lw", 32'h1004, 32'h0, WORD, 1'b0, 1'b0, 0, 4'd0, 64'h0, 32'h11223344);
        access("b2b_sh", 32'h1006, 32'h1234BEEF, HALF, 1'b1, 1'b0, 0, 4'd9, 64'h0, 32'h0);
        access("b2b_lb", 32'h1007, 32'h0, BYTE, 1'b0, 1'b0, 0, 4'd0, 64'h0, 32'h000000BE);
        access("b2b_lw_mis", 32'h1006, 32'h0, WORD, 1'b0, 1'b0, 0, 4'd0, 64'h0, 32'hBEEF3344);
        check_eq("b2b.completions", 64'(n_done - d0), 64'd4);
        check_eq("b2b.bus_cmds", 64'(n_starts - s0), 64'd1);

        // Reset while waiting for a fill; the late fill must be ignored
        lsq_is_requesting = 1'b1;
        address  = 32'h1100;
        mem_size = WORD;
        is_store = 1'b0;
        @(negedge clock);
        check_eq("rmid.cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
        mem2proc_response = 4'd5;
        @(negedge clock);
        mem2proc_response = 4'd0;
        check_eq("rmid.wait_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        d0 = n_done;
        reset = 1'b0;
        lsq_is_requesting = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mem2proc_tag  = 4'd5;
        mem2proc_data = 64'hFFFFFFFF_FFFFFFFF;
        @(negedge clock);
        mem2proc_tag  = 4'd0;
        check_eq("rmid.cmd_idle", 64'(proc2mem_command), 64'(BUS_NONE));
        check_eq("rmid.no_done", 64'(completed), 64'd0);
        @(negedge clock);
        check_eq("rmid.no_pulses", 64'(n_done - d0), 64'd0);
        access("post_rst", 32'h1100, 32'h0, WORD, 1'b0, 1'b1, 0, 4'd10,
               64'h55667788_99AA0011, 32'h99AA0011);
        access("post_hit", 32'h1104, 32'h0, WORD, 1'b0, 1'b0, 0, 4'd0, 64'h0, 32'h55667788);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsq_dcache_ctrl.md
Name: lsq_dcache_ctrl

Overview:
Responder end of the LSQ→dcache interface. It accepts the single head-of-LSQ load or store presented on the DCACHE_IN_PACKET fields and answers with a one-cycle completed pulse plus load data on the DCACHE_OUT_PACKET fields. Internally it is a blocking, direct-mapped, write-through, no-write-allocate data cache. It sits between the LSQ and the tagged memory bus (BUS_LOAD/BUS_STORE, response/tag handshake).

Parameters:
NUM_LINES, 32, number of 8-byte cache lines; power of two; IDX_W = log2(NUM_LINES).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset; asserted when 0
lsq_is_requesting  in  1  head request valid; held stable until completed
address  in  32  request byte address
value  in  32  store data, right-aligned
mem_size  in  MEM_SIZE (2)  BYTE/HALF/WORD/DOUBLE
is_store  in  1  1 = store, 0 = load
completed  out  1  one-cycle done pulse for the accepted request
ld_value  out  32  load result; valid only while completed=1
proc2mem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
proc2mem_addr  out  32  memory address
proc2mem_data  out  64  store data
proc2mem_size  out  MEM_SIZE (2)  access size
mem2proc_response  in  4  nonzero = command accepted, value is the transaction tag
mem2proc_data  in  64  fill data
mem2proc_tag  in  4  tag of the returning fill; 0 = none

Behaviour:
- Address split: offset = addr[2:0]; index = addr[3+IDX_W-1:3]; tag = addr[31:3+IDX_W].
- Arrays: data[NUM_LINES] of 64 bits, tag[NUM_LINES], valid[NUM_LINES]. Reset clears every valid bit.
- Request capture: in IDLE with lsq_is_requesting=1, latch address, value, mem_size and is_store into req_* registers. Latched values are used until RESP. Later changes or a dropped lsq_is_requesting have no effect; there is no squash.
- FSM states: IDLE, LD_REQ, LD_WAIT, ST_REQ, RESP.
- IDLE, load hit (valid and tag match): set ld_value, go to RESP. completed=1 in the next cycle, so hit latency is 1 cycle.
- IDLE, load miss: go to LD_REQ.
- IDLE, store: if it hits, merge the bytes into the line this cycle. Then go to ST_REQ. No allocate on a store miss.
- LD_REQ: drive BUS_LOAD, proc2mem_addr = {req_addr[31:3],3'b0}, size DOUBLE.
  - response = 0: retry next cycle.
  - response ≠ 0: save it as mem_tag and go to LD_WAIT. Command becomes BUS_NONE from then on.
- LD_WAIT: when mem2proc_tag == mem_tag and mem_tag ≠ 0, write the line (data, tag, valid=1), extract ld_value from mem2proc_data, go to RESP.
- ST_REQ: drive BUS_STORE, proc2mem_addr = req_addr, proc2mem_size = req_size, proc2mem_data = {32'h0, req_value}. Hold until response ≠ 0, then go to RESP.
- RESP: completed=1 for exactly one cycle, then IDLE. The LSQ pops its head this cycle; IDLE does not resample until the next cycle, so no request is double-accepted.
- Load extract, zero-extended (sign extension is the consumer's job):
  - BYTE: line byte[offset].
  - HALF: halfword at offset[2:1].
  - WORD and DOUBLE: word at offset[2].
- Store merge uses the same lane rules. Misaligned low offset bits are ignored per size.
- Store completion: ld_value = 0.
- Outputs are registered. Reset values: completed=0, ld_value=0, command=BUS_NONE, addr=0, data=0, size=BYTE, FSM=IDLE, mem_tag=0.
- Reset mid-operation: abandon the transaction. A fill that returns later is ignored because mem_tag=0.
- At most one outstanding memory transaction. A fill in the same cycle as acceptance cannot occur, since LD_WAIT is entered only after acceptance.

Decomposition:
- sys_defs.svh holds MEM_SIZE, BUS_COMMAND, DCACHE_IN_PACKET and DCACHE_OUT_PACKET (completed, value), plus a new DCACHE_STATE enum. The top level may use the packet types in place of loose ports.
- One sub-module, dcache_lane_sel: a combinational byte/half/word extract-and-merge shared by the load and store paths.

Test Plan:
- Cold load: LW 0x1000 (miss). Memory accepts with response 3 after 2 retry cycles; tag 3 returns with data 0x11223344_AABBCCDD. Expect completed for one cycle with ld_value 0xAABBCCDD. A second LW 0x1004 hits: completed one cycle after request, value 0x11223344.
- Store hit merge: line 0x1000 cached, SB 0x1001 value 0xEE. Expect BUS_STORE addr 0x1001 size BYTE held until response ≠ 0, then completed. A following LW 0x1000 hits with 0xAABBEEDD.
- Store miss, no allocate: SW 0x2000 = 0xDEADBEEF. Memory stores it; a following LW 0x2000 misses and issues BUS_LOAD 0x2000.
- Conflict eviction: with NUM_LINES=32, load 0x1000, then 0x1100 (same index), then 0x1000. Expect three BUS_LOADs.
- Back-to-back: LSQ pops on completed and presents a new request the next cycle. Expect exactly one completed per request and no duplicate bus command.
- Reset mid-miss: reset=0 while in LD_WAIT, released, then a stale tag returns. Expect no fill, command BUS_NONE, completed stays 0.
